// File: rtl/dm_port_arbiter_if.sv
// Bundle of signals between the two memory requesters, the arbiter and the data memory.
// Port 0 is the CPU MEM stage. Port 1 is the DMA/debug loader.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// it drives the requester fields and the memory read data.
interface dm_port_arbiter_if;
    // Port 0 (CPU)
    logic        req0;
    logic        we0;
    logic        byte0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic [31:0] pc0;
    logic        gnt0;
    logic        rvalid0;
    logic [31:0] rdata0;
    logic        err0;

    // Port 1 (DMA / debug loader)
    logic        req1;
    logic        we1;
    logic        byte1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        err1;

    // Data memory side
    logic        dm_we;
    logic        dm_byte;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;

    modport slave (
        input  req0, we0, byte0, addr0, wdata0, pc0,
        input  req1, we1, byte1, addr1, wdata1,
        input  dm_rdata,
        output gnt0, rvalid0, rdata0, err0,
        output gnt1, rvalid1, rdata1, err1,
        output dm_we, dm_byte, dm_addr, dm_wdata, dm_pc
    );

    modport master (
        output req0, we0, byte0, addr0, wdata0, pc0,
        output req1, we1, byte1, addr1, wdata1,
        output dm_rdata,
        input  gnt0, rvalid0, rdata0, err0,
        input  gnt1, rvalid1, rdata1, err1,
        input  dm_we, dm_byte, dm_addr, dm_wdata, dm_pc
    );
endinterface

// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// When a request is accepted, its fields are latched and the access runs for one
// ACCESS cycle. The result comes back one cycle later on a registered rvalid/rdata pair.
// Addresses outside the memory are answered with err and never reach the memory.
module dm_port_arbiter #(
    parameter int          DM_WORDS_LOG2 = 12,
    parameter logic [31:0] DMA_PC_TAG    = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              reset,
    dm_port_arbiter_if.slave  bus
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    logic [0:0]  state;
    logic        last_grant;   // port that won the most recent arbitration
    logic        sel;          // port owning the current ACCESS cycle
    logic        lat_we;
    logic        lat_byte;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [31:0] lat_pc;

    logic        any_req;
    logic        pick;
    logic        in_range;

    logic        gnt0_q, gnt1_q;
    logic        rvalid0_q, rvalid1_q;
    logic        err0_q, err1_q;
    logic [31:0] rdata0_q, rdata1_q;

    // Winner selection: a lone requester wins; on a tie the port that did not win last time wins.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            pick = ~last_grant;
        end else begin
            pick = bus.req1;
        end
        in_range = (lat_addr >> (DM_WORDS_LOG2 + 2)) == 32'd0;
    end

    // FSM and request latch: accept one request in IDLE, spend exactly one cycle in ACCESS.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            lat_we     <= 1'b0;
            lat_byte   <= 1'b0;
            lat_addr   <= 32'd0;
            lat_wdata  <= 32'd0;
            lat_pc     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        sel        <= pick;
                        last_grant <= pick;
                        lat_we     <= pick ? bus.we1    : bus.we0;
                        lat_byte   <= pick ? bus.byte1  : bus.byte0;
                        lat_addr   <= pick ? bus.addr1  : bus.addr0;
                        lat_wdata  <= pick ? bus.wdata1 : bus.wdata0;
                        lat_pc     <= pick ? DMA_PC_TAG : bus.pc0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake registers: gnt is high during ACCESS; rvalid/err/rdata are high in the cycle after it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
        end else begin
            gnt0_q    <= (state == IDLE) && any_req && !pick;
            gnt1_q    <= (state == IDLE) && any_req &&  pick;
            rvalid0_q <= (state == ACCESS) && !sel;
            rvalid1_q <= (state == ACCESS) &&  sel;
            err0_q    <= (state == ACCESS) && !sel && !in_range;
            err1_q    <= (state == ACCESS) &&  sel && !in_range;
            // rdata holds its value across stores and errored accesses
            if ((state == ACCESS) && !sel && !lat_we && in_range) begin
                rdata0_q <= bus.dm_rdata;
            end
            if ((state == ACCESS) && sel && !lat_we && in_range) begin
                rdata1_q <= bus.dm_rdata;
            end
        end
    end

    // Memory drive: the latched access is active only in ACCESS; all memory outputs are zero otherwise.
    // NOTE: each output gets a default first so this block can never infer a latch.
    always_comb begin
        bus.dm_we    = 1'b0;
        bus.dm_byte  = 1'b0;
        bus.dm_addr  = 32'd0;
        bus.dm_wdata = 32'd0;
        bus.dm_pc    = 32'd0;
        if (state == ACCESS) begin
            bus.dm_we    = lat_we & in_range;
            bus.dm_byte  = lat_byte;
            bus.dm_addr  = lat_addr;
            bus.dm_wdata = lat_wdata;
            bus.dm_pc    = lat_pc;
        end
    end

    assign bus.gnt0    = gnt0_q;
    assign bus.gnt1    = gnt1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.err0    = err0_q;
    assign bus.err1    = err1_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter. It contains a behavioural data memory with
// combinational read and posedge write. Each access pushes its expected response into
// a per-port scoreboard. The response is popped and compared in the cycle where rvalid rises.
module tb_dm_port_arbiter;

    localparam logic [31:0] TAG = 32'hFFFF_FFFF;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dm_port_arbiter_if bus ();

    dm_port_arbiter #(
        .DM_WORDS_LOG2 (12),
        .DMA_PC_TAG    (TAG)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural data memory: word array indexed by A[13:2]; byte mode reads and writes the A[1:0] lane
    logic [31:0] mem [0:4095];
    logic [11:0] dm_idx;
    logic [1:0]  dm_lane;
    logic [31:0] dm_word;
    logic [31:0] rd_model;

    always_comb begin
        dm_idx  = bus.dm_addr[13:2];
        dm_lane = bus.dm_addr[1:0];
        dm_word = mem[dm_idx];
        rd_model = dm_word;
        if (bus.dm_byte) begin
            case (dm_lane)
                2'd0:    rd_model = {24'd0, dm_word[7:0]};
                2'd1:    rd_model = {24'd0, dm_word[15:8]};
                2'd2:    rd_model = {24'd0, dm_word[23:16]};
                default: rd_model = {24'd0, dm_word[31:24]};
            endcase
        end
    end
    assign bus.dm_rdata = rd_model;

    always @(posedge clk) begin
        if (bus.dm_we) begin
            if (bus.dm_byte) mem[dm_idx][{dm_lane, 3'b000} +: 8] <= bus.dm_wdata[7:0];
            else             mem[dm_idx] <= bus.dm_wdata;
        end
    end

    exp_t        sb0[$];
    exp_t        sb1[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_rd0 = 32'd0;
    logic [31:0] last_rd1 = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares one port's response against its scoreboard. err must never appear without rvalid.
    task automatic check_ret(input int p, input logic rv, input logic er, input logic [31:0] rd);
        exp_t e;
        int   sz;
        sz = (p == 0) ? sb0.size() : sb1.size();
        if (rv) begin
            chk($sformatf("rvalid%0d_expected", p), 32'(sz != 0), 32'd1);
            if (sz != 0) begin
                e = (p == 0) ? sb0.pop_front() : sb1.pop_front();
                chk($sformatf("err%0d", p), 32'(er), 32'(e.err));
                chk($sformatf("rdata%0d", p), rd, e.rdata);
            end
        end else begin
            chk($sformatf("err%0d_idle", p), 32'(er), 32'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_ret(0, bus.rvalid0, bus.err0, bus.rdata0);
        check_ret(1, bus.rvalid1, bus.err1, bus.rdata1);
    endtask

    task automatic drive(input int p, input logic req, input logic we, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc);
        if (p == 0) begin
            bus.req0 = req; bus.we0 = we; bus.byte0 = byt;
            bus.addr0 = addr; bus.wdata0 = wdata; bus.pc0 = pc;
        end else begin
            bus.req1 = req; bus.we1 = we; bus.byte1 = byt;
            bus.addr1 = addr; bus.wdata1 = wdata;
        end
    endtask

    // One access on one port from an idle arbiter. The task checks gnt latency, the ACCESS-cycle memory drive and the response.
    task automatic do_access(input int p, input logic we, input logic byt,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] pc, input logic exp_err,
                             input logic [31:0] load_val, input logic [31:0] exp_pc);
        exp_t e;
        int   waited;
        logic got;
        e.err = exp_err;
        if (!we && !exp_err) begin
            if (p == 0) last_rd0 = load_val; else last_rd1 = load_val;
        end
        e.rdata = (p == 0) ? last_rd0 : last_rd1;
        if (p == 0) sb0.push_back(e); else sb1.push_back(e);
        drive(p, 1'b1, we, byt, addr, wdata, pc);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 20) begin
            tick();
            waited++;
            got = (p == 0) ? bus.gnt0 : bus.gnt1;
        end
        chk("gnt_latency", 32'(waited), 32'd1);
        if (got) begin
            chk("dm_pc", bus.dm_pc, exp_pc);
            chk("dm_we", 32'(bus.dm_we), 32'(we & ~exp_err));
            chk("dm_addr", bus.dm_addr, addr);
        end
        drive(p, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        chk("sb_drained", 32'((p == 0) ? sb0.size() : sb1.size()), 32'd0);
    endtask

    // Both ports hold word loads of 0x20 for n cycles. Grants must alternate 0,1,0,1 with one every two cycles.
    task automatic tie_run(input int n, input logic [31:0] exp_rd);
        exp_t e;
        int   seq[$];
        int   at[$];
        e.err   = 1'b0;
        e.rdata = exp_rd;
        last_rd0 = exp_rd;
        last_rd1 = exp_rd;
        for (int k = 0; k < n / 4; k++) begin
            sb0.push_back(e);
            sb1.push_back(e);
        end
        drive(0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 32'h200);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'd0, 32'd0);
        for (int i = 0; i < n; i++) begin
            tick();
            chk("gnt_exclusive", 32'(bus.gnt0 & bus.gnt1), 32'd0);
            if (bus.gnt0) begin seq.push_back(0); at.push_back(i); end
            if (bus.gnt1) begin seq.push_back(1); at.push_back(i); end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        chk("tie_grant_count", 32'(seq.size()), 32'(n / 2));
        for (int k = 0; k < seq.size(); k++) begin
            chk($sformatf("tie_grant_port_%0d", k), 32'(seq[k]), 32'(k % 2));
            chk($sformatf("tie_grant_cycle_%0d", k), 32'(at[k]), 32'(2 * k));
        end
        chk("tie_sb0_drained", 32'(sb0.size()), 32'd0);
        chk("tie_sb1_drained", 32'(sb1.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
        chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
        chk("rst_rdata0", bus.rdata0, 32'd0);
        chk("rst_dm_we", 32'(bus.dm_we), 32'd0);
        chk("rst_dm_addr", bus.dm_addr, 32'd0);
        chk("rst_dm_pc", bus.dm_pc, 32'd0);
        reset = 1'b0;

        // 1: reset during a store's ACCESS cycle aborts the store
        drive(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 32'h100);
        tick();
        chk("c1_gnt0", 32'(bus.gnt0), 32'd1);
        chk("c1_dm_we_before", 32'(bus.dm_we), 32'd1);
        reset = 1'b1;
        #1;
        chk("c1_dm_we_async", 32'(bus.dm_we), 32'd0);
        chk("c1_gnt0_async", 32'(bus.gnt0), 32'd0);
        chk("c1_dm_addr_async", bus.dm_addr, 32'd0);
        chk("c1_dm_wdata_async", bus.dm_wdata, 32'd0);
        drive(0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        chk("c1_mem_word4", mem[4], 32'd0);
        tie_run(4, 32'd0);

        // 2: port 0 word store then load
        do_access(0, 1'b1, 1'b0, 32'h20, 32'hDEAD_BEEF, 32'h400, 1'b0, 32'd0, 32'h400);
        do_access(0, 1'b0, 1'b0, 32'h20, 32'd0, 32'h404, 1'b0, 32'hDEAD_BEEF, 32'h404);

        // 3: port 1 word store, byte store into lane 1, byte load and word load
        do_access(1, 1'b1, 1'b0, 32'h20, 32'h1122_3344, 32'd0, 1'b0, 32'd0, TAG);
        do_access(1, 1'b1, 1'b1, 32'h21, 32'h0000_00AA, 32'd0, 1'b0, 32'd0, TAG);
        do_access(1, 1'b0, 1'b1, 32'h21, 32'd0, 32'd0, 1'b0, 32'h0000_00AA, TAG);
        do_access(1, 1'b0, 1'b0, 32'h20, 32'd0, 32'd0, 1'b0, 32'h1122_AA44, TAG);

        // 4: both ports requesting continuously for 8 cycles
        tie_run(8, 32'h1122_AA44);

        // 5: out-of-range store on port 1 is errored and never written
        do_access(1, 1'b1, 1'b0, 32'h0001_0000, 32'h5555_5555, 32'd0, 1'b1, 32'd0, TAG);
        chk("c5_mem_word0", mem[0], 32'd0);
        chk("c5_mem_word8", mem[8], 32'h1122_AA44);
        tick();

        chk("final_sb0_empty", 32'(sb0.size()), 32'd0);
        chk("final_sb1_empty", 32'(sb1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
